// File: rtl/gate_exerciser.sv
// rtl/gate_exerciser.sv - clocked sweep-and-compare checker for small combinational gates
// Drives every input vector in ascending order, samples the gate after SETTLE cycles, tallies mismatches.
module gate_exerciser #(
  parameter int                    N_IN   = 2,
  parameter logic [2**N_IN-1:0]    TRUTH  = 4'b0111,
  parameter int                    SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   stim,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic              fail_valid,
  output logic [N_IN-1:0]   first_fail_vec
);

  typedef enum logic [1:0] {IDLE, HOLD, CHECK, DONE} state_t;

  localparam logic [N_IN-1:0] VEC_LAST = '1;
  localparam logic [3:0]      CNT_LAST = 4'(SETTLE - 1);

  state_t          state;
  logic [N_IN-1:0] vec;
  logic [3:0]      cnt;
  logic            mismatch;
  logic [N_IN:0]   err_next;

  // Case inequality so an X/Z from the gate is flagged in simulation.
  always_comb begin
    mismatch = 1'b0;
    err_next = err_count;
    mismatch = (dut_out !== TRUTH[vec]);
    err_next = err_count + {{N_IN{1'b0}}, mismatch};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      vec            <= '0;
      cnt            <= '0;
      stim           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            vec            <= '0;
            stim           <= '0;
            cnt            <= '0;
            busy           <= 1'b1;
            state          <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == CNT_LAST) state <= CHECK;
          else                 cnt   <= cnt + 1'b1;
        end
        CHECK: begin
          err_count <= err_next;
          if (mismatch && !fail_valid) begin
            fail_valid     <= 1'b1;
            first_fail_vec <= vec;
          end
          if (vec == VEC_LAST) begin
            // pass uses the post-compare count so the last vector is included.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
            stim  <= '0;
          end else begin
            vec   <= vec + 1'b1;
            stim  <= vec + 1'b1;
            cnt   <= '0;
            state <= HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// tb/tb_gate_exerciser.sv - self-checking bench for gate_exerciser with default NAND parameters
module tb_gate_exerciser;

  localparam logic [3:0] TRUTH_EXP = 4'b0111;
  localparam logic [3:0] NAND_RESP = 4'b0111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] stim;
  logic       dut_out;
  logic       busy, done, pass, fail_valid;
  logic [2:0] err_count;
  logic [1:0] first_fail_vec;

  logic [3:0] resp_tbl;
  logic       use_reg;
  logic       reg_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_exerciser dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stim           (stim),
    .dut_out        (dut_out),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .fail_valid     (fail_valid),
    .first_fail_vec (first_fail_vec)
  );

  // Gate models: combinational lookup, or a NAND delayed by one register.
  always @(posedge clk) reg_out <= NAND_RESP[stim];
  assign dut_out = use_reg ? reg_out : resp_tbl[stim];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full sweep from IDLE or DONE; mid_c >= 1 pulses start during the sweep.
  task automatic run_sweep(input logic [3:0] resp, input bit reg_mode, input int mid_c);
    int         exp_err = 0;
    bit         exp_fv  = 0;
    logic [1:0] exp_ff  = 2'd0;
    resp_tbl = resp;
    use_reg  = reg_mode;
    for (int i = 0; i < 4; i++) begin
      if ((reg_mode ? NAND_RESP[i] : resp[i]) !== TRUTH_EXP[i]) begin
        if (!exp_fv) begin
          exp_fv = 1;
          exp_ff = 2'(i);
        end
        exp_err++;
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin
        if (c == mid_c) start = 1'b1;
        step();
        start = 1'b0;
      end
      chk("sweep_stim", 32'(stim), 32'(c / 2));
      chk("sweep_busy", 32'(busy), 32'd1);
      chk("sweep_done", 32'(done), 32'd0);
    end
    step();
    chk("end_done", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_stim", 32'(stim), 32'd0);
    chk("end_pass", 32'(pass), 32'(exp_err == 0));
    chk("end_err_count", 32'(err_count), 32'(exp_err));
    chk("end_fail_valid", 32'(fail_valid), 32'(exp_fv));
    chk("end_first_fail_vec", 32'(first_fail_vec), 32'(exp_ff));
    repeat (2) step();
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_err_count", 32'(err_count), 32'(exp_err));
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    resp_tbl = NAND_RESP;
    use_reg  = 1'b0;
    repeat (2) step();
    chk("rst_stim", 32'(stim), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_fail_valid", 32'(fail_valid), 32'd0);
    chk("rst_first_fail_vec", 32'(first_fail_vec), 32'd0);

    // Reset and start together: reset wins.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();
    chk("idle_busy", 32'(busy), 32'd0);

    run_sweep(NAND_RESP, 1'b0, -1);   // ideal NAND
    run_sweep(4'b1111, 1'b0, -1);     // tied high
    run_sweep(4'b1000, 1'b0, -1);     // AND instead of NAND
    run_sweep(NAND_RESP, 1'b0, 4);    // start during vec 2 ignored
    run_sweep(NAND_RESP, 1'b1, -1);   // registered NAND
    run_sweep(4'bxxxx, 1'b0, -1);     // floating output

    // Reset mid-sweep while vec == 2, with errors already counted.
    resp_tbl = 4'b1000;
    use_reg  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("mid_stim_before", 32'(stim), 32'd2);
    chk("mid_err_before", 32'(err_count), 32'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_stim", 32'(stim), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    chk("mid_rst_fail_valid", 32'(fail_valid), 32'd0);
    repeat (10) step();
    chk("post_rst_idle_busy", 32'(busy), 32'd0);
    chk("post_rst_idle_done", 32'(done), 32'd0);
    chk("post_rst_idle_stim", 32'(stim), 32'd0);

    // Randomized gate responses, gaps and stray mid-sweep starts.
    for (int n = 0; n < 24; n++) begin
      logic [3:0] r;
      int         gap;
      int         mid;
      r   = 4'($urandom_range(0, 15));
      gap = $urandom_range(0, 3);
      mid = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : -1;
      repeat (gap) step();
      run_sweep(r, 1'b0, mid);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
